csi_hs_tx_sequencer: RTL and testbench

- Transmit-side lane controller for the CSI data lanes.
- Sequences the D-PHY start-of-transmission: LP11 → LP01 → LP00 → HS-zero → sync word.
- Then drains one packet of words from the CSI TX FIFO onto the per-lane HS word bus, drives HS-trail, and returns the lanes to LP11 stop state.
- Sits between the packet FIFO and the per-lane serializers/line drivers.

---
 rtl/csi_hs_tx_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_csi_hs_tx_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_hs_tx_sequencer.sv
// csi_hs_tx_sequencer: transmit-side lane controller for the CSI data lanes.
// Sequences the D-PHY start of transmission (LP11 -> LP01 -> LP00 -> HS0 ->
// sync word), drains one packet from the show-ahead CSI TX FIFO onto the
// per-lane HS word bus, drives HS-trail and returns the lanes to LP11.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   tx_req, tx_len start request and packet length (FIFO words), IDLE only
//   fifo_data      show-ahead FIFO head; lane k uses bits [k*W +: W]
//   fifo_empty     FIFO empty
//   fifo_rd_en     pop FIFO head (combinational from state and fifo_empty)
//   hs_word        per-lane HS word, LSB transmitted first
//   hs_valid       hs_word driven (SYNC/DATA/TRAIL)
//   line_state     0 HS0, 1 HS1, 2 LP00, 3 LP01, 4 LP10, 5 LP11
//   busy           sequencer not idle
//   done           one-cycle pulse at end of packet
//   underflow      one-cycle pulse when a DATA word was needed with FIFO empty
//   pkt_cnt        (CSI_TX_SEQ_STATS_EN) wrapping packet counter
//   underflow_cnt  (CSI_TX_SEQ_STATS_EN) saturating underflow counter
//
// Optional feature macro: CSI_TX_SEQ_STATS_EN.
//
// Registered outputs describe the state the FSM occupied in the previous
// cycle, so the FIFO head popped during a DATA state cycle appears on hs_word
// in the following cycle, aligned with its hs_valid/line_state.
module csi_hs_tx_sequencer #(
  parameter int unsigned N_DATA_LANES         = 2,
  parameter int unsigned HS_TX_WORD_BIT_WIDTH = 8,
  parameter int unsigned CSI_FIFO_DATA_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH            = 16,
  parameter int unsigned T_LPX                = 4,
  parameter int unsigned T_HS_PREPARE         = 3,
  parameter int unsigned T_HS_ZERO            = 10,
  parameter int unsigned T_HS_TRAIL           = 5
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          tx_req,
  input  logic [LEN_WIDTH-1:0]                          tx_len,
  input  logic [CSI_FIFO_DATA_WIDTH-1:0]                fifo_data,
  input  logic                                          fifo_empty,
  output logic                                          fifo_rd_en,
  output logic [N_DATA_LANES*HS_TX_WORD_BIT_WIDTH-1:0]  hs_word,
  output logic                                          hs_valid,
  output logic [3:0]                                    line_state,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          underflow
`ifdef CSI_TX_SEQ_STATS_EN
  ,
  output logic [15:0]                                   pkt_cnt,
  output logic [7:0]                                    underflow_cnt
`endif
);

  localparam int unsigned W      = HS_TX_WORD_BIT_WIDTH;
  localparam int unsigned NL     = N_DATA_LANES;
  localparam int unsigned WORD_W = NL * W;

  localparam logic [3:0] LS_HS0  = 4'd0;
  localparam logic [3:0] LS_LP00 = 4'd2;
  localparam logic [3:0] LS_LP01 = 4'd3;
  localparam logic [3:0] LS_LP11 = 4'd5;

  // Sync byte 0xB8 zero-extended or truncated to the lane word width.
  localparam logic [W-1:0] SYNC_LANE = W'(8'hB8);

  localparam logic [LEN_WIDTH-1:0] LPX_LAST     = LEN_WIDTH'(T_LPX - 1);
  localparam logic [LEN_WIDTH-1:0] PREPARE_LAST = LEN_WIDTH'(T_HS_PREPARE - 1);
  localparam logic [LEN_WIDTH-1:0] ZERO_LAST    = LEN_WIDTH'(T_HS_ZERO - 1);
  localparam logic [LEN_WIDTH-1:0] TRAIL_LAST   = LEN_WIDTH'(T_HS_TRAIL - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LPREQ = 3'd1,
    S_PREP  = 3'd2,
    S_ZERO  = 3'd3,
    S_SYNC  = 3'd4,
    S_DATA  = 3'd5,
    S_TRAIL = 3'd6,
    S_EXIT  = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [NL-1:0]         last_msb_q, last_msb_d;
  logic [WORD_W-1:0]     hs_word_q, hs_word_d;
  logic                  hs_valid_q, hs_valid_d;
  logic [3:0]            line_state_q, line_state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  underflow_q, underflow_d;

  // Pop only while draining; held off during reset so an abort never consumes a word.
  assign fifo_rd_en = rst_n && (state_q == S_DATA) && !fifo_empty;

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    last_msb_d   = last_msb_q;
    hs_word_d    = '0;
    hs_valid_d   = 1'b0;
    line_state_d = LS_LP11;
    busy_d       = 1'b1;
    done_d       = 1'b0;
    underflow_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (tx_req) begin
          len_d   = tx_len;
          cnt_d   = '0;
          state_d = S_LPREQ;
        end
      end
      S_LPREQ: begin
        line_state_d = LS_LP01;
        if (cnt_q == LPX_LAST) begin
          cnt_d   = '0;
          state_d = S_PREP;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      S_PREP: begin
        line_state_d = LS_LP00;
        if (cnt_q == PREPARE_LAST) begin
          cnt_d   = '0;
          state_d = S_ZERO;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      S_ZERO: begin
        line_state_d = LS_HS0;
        if (cnt_q == ZERO_LAST) begin
          cnt_d   = '0;
          state_d = S_SYNC;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      S_SYNC: begin
        line_state_d = LS_HS0;
        hs_valid_d   = 1'b1;
        hs_word_d    = {NL{SYNC_LANE}};
        last_msb_d   = {NL{SYNC_LANE[W-1]}};
        cnt_d        = '0;
        state_d      = (len_q == '0) ? S_TRAIL : S_DATA;
      end
      S_DATA: begin
        line_state_d = LS_HS0;
        hs_valid_d   = 1'b1;
        // An empty FIFO still consumes a word slot so the packet length holds.
        if (fifo_empty) begin
          underflow_d = 1'b1;
        end else begin
          hs_word_d = WORD_W'(fifo_data);
        end
        for (int unsigned k = 0; k < NL; k++) begin
          last_msb_d[k] = hs_word_d[k*W + W - 1];
        end
        if (cnt_q == len_q - LEN_WIDTH'(1)) begin
          cnt_d   = '0;
          state_d = S_TRAIL;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      S_TRAIL: begin
        line_state_d = LS_HS0;
        hs_valid_d   = 1'b1;
        // Each lane holds the complement of the last bit it transmitted.
        for (int unsigned k = 0; k < NL; k++) begin
          hs_word_d[k*W +: W] = {W{~last_msb_q[k]}};
        end
        if (cnt_q == TRAIL_LAST) begin
          cnt_d   = '0;
          state_d = S_EXIT;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      S_EXIT: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      last_msb_q   <= '0;
      hs_word_q    <= '0;
      hs_valid_q   <= 1'b0;
      line_state_q <= LS_LP11;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      last_msb_q   <= last_msb_d;
      hs_word_q    <= hs_word_d;
      hs_valid_q   <= hs_valid_d;
      line_state_q <= line_state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign hs_word    = hs_word_q;
  assign hs_valid   = hs_valid_q;
  assign line_state = line_state_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underflow  = underflow_q;

`ifdef CSI_TX_SEQ_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  underflow_cnt_q, underflow_cnt_d;

  // Packet counter wraps; underflow counter saturates at its maximum.
  always_comb begin
    pkt_cnt_d       = pkt_cnt_q;
    underflow_cnt_d = underflow_cnt_q;
    if (done_d) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if (underflow_d && (underflow_cnt_q != 8'hFF)) begin
      underflow_cnt_d = underflow_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt_q       <= '0;
      underflow_cnt_q <= '0;
    end else begin
      pkt_cnt_q       <= pkt_cnt_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign pkt_cnt       = pkt_cnt_q;
  assign underflow_cnt = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_csi_hs_tx_sequencer.sv
// Testbench for csi_hs_tx_sequencer: scoreboard of expected per-cycle lane
// outputs, filled by the stimulus and drained by an independent monitor.
module tb_csi_hs_tx_sequencer;

  localparam int T_LPX        = 4;
  localparam int T_HS_PREPARE = 3;
  localparam int T_HS_ZERO    = 10;
  localparam int T_HS_TRAIL   = 5;

  typedef struct packed {
    logic [3:0]  ls;
    logic        hv;
    logic [15:0] w;
    logic        busy;
    logic        done;
    logic        uf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_req;
  logic [15:0] tx_len;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] hs_word;
  logic        hs_valid;
  logic [3:0]  line_state;
  logic        busy;
  logic        done;
  logic        underflow;
`ifdef CSI_TX_SEQ_STATS_EN
  logic [15:0] pkt_cnt;
  logic [7:0]  underflow_cnt;
`endif

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t mon_got;
  logic mon_en = 1'b0;

  logic [15:0] fifo_mem [16];
  logic [7:0]  rd_ptr = 8'd0;
  logic [7:0]  wr_ptr = 8'd0;
  int          pops = 0;
  logic [15:0] pkt_words [8];

  always #5 clk = ~clk;

  csi_hs_tx_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_req     (tx_req),
    .tx_len     (tx_len),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .hs_word    (hs_word),
    .hs_valid   (hs_valid),
    .line_state (line_state),
    .busy       (busy),
    .done       (done),
    .underflow  (underflow)
`ifdef CSI_TX_SEQ_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt),
    .underflow_cnt (underflow_cnt)
`endif
  );

  // Show-ahead FIFO model.
  assign fifo_data  = fifo_mem[rd_ptr[3:0]];
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) begin
        $display("FAIL pop_when_empty: got fifo_rd_en=1 with empty FIFO, required 0");
        errors++;
      end else begin
        rd_ptr <= rd_ptr + 8'd1;
        pops++;
      end
    end
  end

  // Monitor: every cycle the DUT leaves LP11 or flags done is one scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && (line_state != 4'd5 || done)) begin
      checks++;
      mon_got = '{ls: line_state, hv: hs_valid, w: hs_word, busy: busy, done: done, uf: underflow};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got ls=%0d hv=%0b word=%h done=%0b uf=%0b, required no activity",
                 line_state, hs_valid, hs_word, done, underflow);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL stream: got ls=%0d hv=%0b word=%h busy=%0b done=%0b uf=%0b, required ls=%0d hv=%0b word=%h busy=%0b done=%0b uf=%0b",
                   mon_got.ls, mon_got.hv, mon_got.w, mon_got.busy, mon_got.done, mon_got.uf,
                   mon_e.ls, mon_e.hv, mon_e.w, mon_e.busy, mon_e.done, mon_e.uf);
        end
      end
    end
  end

  task automatic push_e(input logic [3:0] ls, input logic hv, input logic [15:0] w,
                        input logic dn, input logic uf);
    exp_q.push_back('{ls: ls, hv: hv, w: w, busy: 1'b1, done: dn, uf: uf});
  endtask

  // Expected lane stream for one packet; words beyond 'avail' are underflows.
  task automatic push_pkt(input int len, input int avail);
    logic [15:0] last;
    logic [15:0] w;
    logic [15:0] tw;
    for (int i = 0; i < T_LPX; i++)        push_e(4'd3, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < T_HS_PREPARE; i++) push_e(4'd2, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < T_HS_ZERO; i++)    push_e(4'd0, 1'b0, 16'h0, 1'b0, 1'b0);
    push_e(4'd0, 1'b1, 16'hB8B8, 1'b0, 1'b0);
    last = 16'hB8B8;
    for (int i = 0; i < len; i++) begin
      w = (i < avail) ? pkt_words[i] : 16'h0000;
      push_e(4'd0, 1'b1, w, 1'b0, (i >= avail));
      last = w;
    end
    tw = {{8{~last[15]}}, {8{~last[7]}}};
    for (int i = 0; i < T_HS_TRAIL; i++) push_e(4'd0, 1'b1, tw, 1'b0, 1'b0);
    push_e(4'd5, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic fifo_push(input logic [15:0] w);
    fifo_mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic start_pkt(input logic [15:0] len);
    @(negedge clk);
    tx_req = 1'b1;
    tx_len = len;
    @(negedge clk);
    tx_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got %0d entries pending busy=%0b, required drained and idle",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic check_pops(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s_pops: got %0d, required %0d", name, got, req);
    end
  endtask

  int p0;
  bit hit;
`ifdef CSI_TX_SEQ_STATS_EN
  logic [15:0] pc0;
`endif

  initial begin
    rst_n  = 1'b0;
    tx_req = 1'b0;
    tx_len = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Idle after reset: LP11, nothing driven, no pops.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (line_state !== 4'd5 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || hs_valid !== 1'b0 ||
          done !== 1'b0 || underflow !== 1'b0 || hs_word !== 16'h0) begin
        errors++;
        $display("FAIL idle[%0d]: got ls=%0d busy=%0b rd=%0b hv=%0b done=%0b uf=%0b word=%h, required 5/0/0/0/0/0/0000",
                 i, line_state, busy, fifo_rd_en, hs_valid, done, underflow, hs_word);
      end
    end

    // Three-word packet.
    pkt_words[0] = 16'h1234; pkt_words[1] = 16'h5678; pkt_words[2] = 16'h9ABC;
    for (int i = 0; i < 3; i++) fifo_push(pkt_words[i]);
    p0 = pops;
    push_pkt(3, 3);
    start_pkt(16'd3);
    wait_idle("len3");
    check_pops("len3", pops - p0, 3);

    // Zero-length packet: sync straight into trail.
    p0 = pops;
    push_pkt(0, 0);
    start_pkt(16'd0);
    wait_idle("len0");
    check_pops("len0", pops - p0, 0);

    // Underflow: four words requested, two available.
    pkt_words[0] = 16'h8001; pkt_words[1] = 16'h0180;
    fifo_push(16'h8001); fifo_push(16'h0180);
    p0 = pops;
    push_pkt(4, 2);
    start_pkt(16'd4);
    wait_idle("underflow");
    check_pops("underflow", pops - p0, 2);
`ifdef CSI_TX_SEQ_STATS_EN
    checks++;
    if (underflow_cnt !== 8'd2) begin
      errors++;
      $display("FAIL underflow_cnt: got %0d, required 2", underflow_cnt);
    end
`endif

    // Reset while the second data word is on the lanes.
    pkt_words[0] = 16'hA1B2; pkt_words[1] = 16'hC3D4; pkt_words[2] = 16'hE5F6;
    for (int i = 0; i < 3; i++) fifo_push(pkt_words[i]);
    p0 = pops;
    push_pkt(3, 3);
    start_pkt(16'd3);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hs_valid && hs_word == 16'hC3D4) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_wait: got no DATA word C3D4 within bound, required it");
    end
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (line_state !== 4'd5 || hs_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got ls=%0d hv=%0b busy=%0b done=%0b, required 5/0/0/0",
               line_state, hs_valid, busy, done);
    end
    repeat (8) @(negedge clk);
    check_pops("abort", pops - p0, 2);

    // Restart after abort: leftover word E5F6 is still at the FIFO head.
    pkt_words[0] = 16'hE5F6;
    p0 = pops;
    push_pkt(1, 1);
    start_pkt(16'd1);
    wait_idle("restart");
    check_pops("restart", pops - p0, 1);

    // tx_req pulsed during ZERO is ignored: exactly one packet.
    pkt_words[0] = 16'h1111;
    fifo_push(16'h1111);
    fifo_push(16'h2222);
`ifdef CSI_TX_SEQ_STATS_EN
    pc0 = pkt_cnt;
`endif
    p0 = pops;
    push_pkt(1, 1);
    start_pkt(16'd1);
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && line_state == 4'd0 && !hs_valid) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL zero_wait: got no HS0 prefix within bound, required it");
    end
    tx_req = 1'b1;
    tx_len = 16'd1;
    @(negedge clk);
    tx_req = 1'b0;
    wait_idle("ignored_req");
    repeat (30) @(negedge clk);
    check_pops("ignored_req", pops - p0, 1);
    checks++;
    if (busy !== 1'b0 || line_state !== 4'd5) begin
      errors++;
      $display("FAIL ignored_req_idle: got busy=%0b ls=%0d, required 0/5", busy, line_state);
    end
`ifdef CSI_TX_SEQ_STATS_EN
    checks++;
    if (pkt_cnt - pc0 !== 16'd1) begin
      errors++;
      $display("FAIL pkt_cnt_delta: got %0d, required 1", pkt_cnt - pc0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
